mul_share_arbiter: RTL and testbench

- Time-shares one combinational 4x4 unsigned multiplier between N_REQ requesters.
- Each requester issues an operand pair over a valid/ready handshake.
- The block picks one requester with a round-robin grant, drives the shared multiplier from registered operands, and captures the 8-bit product.
- The product is returned on a single tagged response channel. The block sits in front of the multiplier, which is instantiated outside this block.

---
 rtl/mul_share_arbiter_if.sv | 32 +++
 rtl/mul_share_arbiter.sv | 121 ++++++++++++
 tb/tb_mul_share_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arbiter_if.sv
// ============================================================================
// Module   : mul_share_arbiter_if
// Purpose  : Requester operand channels and tagged result channel of the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mul_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req_valid;
  logic [4*N_REQ-1:0] req_a;
  logic [4*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               resp_valid;
  logic [ID_W-1:0]    resp_id;
  logic [7:0]         resp_product;
  logic               resp_ready;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_product
  );
endinterface

`default_nettype wire

// File: rtl/mul_share_arbiter.sv
// ============================================================================
// Module   : mul_share_arbiter
// Purpose  : Round-robin time-sharing of one external 4x4 multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  mul_share_arbiter_if.slave  bus,
  output logic [3:0]          mul_a,
  output logic [3:0]          mul_b,
  input  logic [7:0]          mul_product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_resp_id;
  logic [7:0]       r_resp_product;
  logic             r_resp_valid;
  logic [3:0]       r_mul_a;
  logic [3:0]       r_mul_b;

  logic             w_found;
  logic [ID_W-1:0]  w_grant;
  logic [ID_W-1:0]  w_cand;
  logic [ID_W:0]    w_sum;
  logic [N_REQ-1:0] w_ready;
  logic [ID_W-1:0]  w_next_ptr;

  // First valid requester scanning upward from r_rr_ptr, wrapping at N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(N_REQ);
      end
      w_cand = w_sum[ID_W-1:0];
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Gated by rst so the accept drops the moment reset is applied.
  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && !rst && w_found) begin
      w_ready[w_grant] = 1'b1;
    end
  end

  assign w_next_ptr = (r_resp_id == ID_W'(N_REQ-1)) ? '0 : r_resp_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_id           <= '0;
      r_resp_id      <= '0;
      r_resp_product <= '0;
      r_resp_valid   <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_mul_a <= bus.req_a[{w_grant, 2'b00} +: 4];
            r_mul_b <= bus.req_b[{w_grant, 2'b00} +: 4];
            r_id    <= w_grant;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_resp_product <= mul_product;
          r_resp_id      <= r_id;
          r_resp_valid   <= 1'b1;
          r_state        <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= w_next_ptr;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_id      = r_resp_id;
  assign bus.resp_product = r_resp_product;
  assign mul_a            = r_mul_a;
  assign mul_b            = r_mul_b;

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
// ============================================================================
// Module   : tb_mul_share_arbiter
// Purpose  : Transaction-level reference checking of mul_share_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_share_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_product;

  always #5 clk = ~clk;

  mul_share_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus ();

  // Stand-in for the external shared multiplier.
  assign mul_product = 8'(mul_a) * 8'(mul_b);

  mul_share_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: one outstanding transaction, result 2 edges after accept.
  bit         m_busy;
  int         m_age;
  int         m_ptr;
  int         m_id;
  int         m_prod;
  logic [3:0] m_last_a;
  logic [3:0] m_last_b;

  int         obs_grants[$];
  bit         last_exp_rv;
  logic [7:0] obs_last_prod;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [4*N-1:0] a,
                      input logic [4*N-1:0] b, input logic rr);
    int         g;
    logic [N-1:0] exp_ready;
    bit         exp_rv;
    @(negedge clk);
    bus.req_valid  = v;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.resp_ready = rr;
    #1;
    g = m_busy ? -1 : pick(v, m_ptr);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_value("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    exp_rv = m_busy && (m_age >= 2);
    check_value("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check_value("resp_id", 32'(bus.resp_id), 32'(m_id));
      check_value("resp_product", 32'(bus.resp_product), 32'(m_prod));
    end
    check_value("mul_a", 32'(mul_a), 32'(m_last_a));
    check_value("mul_b", 32'(mul_b), 32'(m_last_b));
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) obs_grants.push_back(i);
    last_exp_rv = exp_rv;
    if (exp_rv && rr) obs_last_prod = bus.resp_product;
    // Advance the reference across the coming rising edge.
    if (m_busy) begin
      if (exp_rv && rr) begin
        m_busy = 1'b0;
        m_ptr  = (m_id + 1) % N;
      end else begin
        m_age++;
      end
    end else if (g >= 0) begin
      m_busy   = 1'b1;
      m_age    = 1;
      m_id     = g;
      m_last_a = a[4*g +: 4];
      m_last_b = b[4*g +: 4];
      m_prod   = int'(m_last_a) * int'(m_last_b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    check_value("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_value("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_value("rst_mul_a", 32'(mul_a), 32'd0);
    check_value("rst_mul_b", 32'(mul_b), 32'd0);
    check_value("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check_value("rst_resp_product", 32'(bus.resp_product), 32'd0);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_busy   = 1'b0;
    m_age    = 0;
    m_ptr    = 0;
    m_id     = 0;
    m_last_a = '0;
    m_last_b = '0;
    obs_grants.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_busy && n < 20) begin
      step('0, '0, '0, 1'b1);
      n++;
    end
    if (m_busy) check_value("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_txn(input int idx, input logic [3:0] a, input logic [3:0] b);
    logic [N-1:0]   v;
    logic [4*N-1:0] av;
    logic [4*N-1:0] bv;
    int             n;
    v = '0; v[idx] = 1'b1;
    av = '0; av[4*idx +: 4] = a;
    bv = '0; bv[4*idx +: 4] = b;
    n = 0;
    while (!m_busy && n < 20) begin
      step(v, av, bv, 1'b1);
      n++;
    end
    if (!m_busy) check_value("accept_timeout", 32'd1, 32'd0);
    drain();
  endtask

  logic [4*N-1:0] ra;
  logic [4*N-1:0] rb;
  int             n;

  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    do_reset();

    // Single request 7*9 with minimum issue interval.
    step(4'b0001, 16'h0007, 16'h0009, 1'b1);
    check_value("sr_ready", 32'(bus.req_ready), 32'd1);
    step('0, '0, '0, 1'b1);
    check_value("sr_calc_valid", 32'(bus.resp_valid), 32'd0);
    step('0, '0, '0, 1'b1);
    check_value("sr_valid", 32'(bus.resp_valid), 32'd1);
    check_value("sr_id", 32'(bus.resp_id), 32'd0);
    check_value("sr_product", 32'(bus.resp_product), 32'd63);
    step(4'b0001, 16'h0007, 16'h0009, 1'b1);
    check_value("sr_reissue", 32'(bus.req_ready), 32'd1);
    drain();

    // Operand corners.
    run_txn(0, 4'd0, 4'($urandom_range(0, 15)));
    check_value("corner_zero", 32'(obs_last_prod), 32'd0);
    run_txn(0, 4'd15, 4'd15);
    check_value("corner_225", 32'(obs_last_prod), 32'd225);
    run_txn(0, 4'd1, 4'd15);
    check_value("corner_15", 32'(obs_last_prod), 32'd15);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_txn(2, 4'(a), 4'(b));

    // Round-robin with every requester held valid.
    do_reset();
    for (int i = 0; i < N; i++) begin
      ra[4*i +: 4] = 4'(i + 3);
      rb[4*i +: 4] = 4'(2*i + 5);
    end
    repeat (16) step('1, ra, rb, 1'b1);
    check_value("rr_count_ok", 32'(obs_grants.size() >= 5), 32'd1);
    if (obs_grants.size() >= 5) begin
      check_value("rr_g0", 32'(obs_grants[0]), 32'd0);
      check_value("rr_g1", 32'(obs_grants[1]), 32'd1);
      check_value("rr_g2", 32'(obs_grants[2]), 32'd2);
      check_value("rr_g3", 32'(obs_grants[3]), 32'd3);
      check_value("rr_g4", 32'(obs_grants[4]), 32'd0);
    end
    drain();

    // Backpressure in RESP with all requesters waiting.
    n = 0;
    do begin
      step('1, ra, rb, 1'b0);
      n++;
    end while (!last_exp_rv && n < 10);
    check_value("bp_reached_resp", 32'(last_exp_rv), 32'd1);
    repeat (5) step('1, ra, rb, 1'b0);
    step('1, ra, rb, 1'b1);
    step('1, ra, rb, 1'b1);
    check_value("bp_back_idle", 32'(|bus.req_ready), 32'd1);
    drain();

    // Asynchronous reset while in CALC.
    step(4'b0100, ra, rb, 1'b1);
    do_reset();
    step('1, ra, rb, 1'b1);
    check_value("post_rst_grant", 32'(bus.req_ready), 32'b0001);

    // Requester 1 pulses only while RESP is stalled.
    n = 0;
    do begin
      step('0, ra, rb, 1'b0);
      n++;
    end while (!last_exp_rv && n < 10);
    step(4'b0010, ra, rb, 1'b0);
    check_value("wd_no_ready", 32'(bus.req_ready), 32'd0);
    step('0, ra, rb, 1'b0);
    step('0, ra, rb, 1'b1);
    step('1, ra, rb, 1'b1);
    check_value("wd_next_grant", 32'(bus.req_ready), 32'b0010);
    drain();

    // Randomized traffic with withdrawals and random backpressure.
    for (int t = 0; t < 1500; t++) begin
      step(N'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
